// File: rtl/timer_pkg.sv
// Shared constants and state type for the memory-mapped interval timer.
package timer_pkg;

   localparam logic [4:0] OFS_STATUS  = 5'h00;
   localparam logic [4:0] OFS_CONTROL = 5'h04;
   localparam logic [4:0] OFS_PERIODL = 5'h08;
   localparam logic [4:0] OFS_PERIODH = 5'h0C;
   localparam logic [4:0] OFS_SNAPL   = 5'h10;
   localparam logic [4:0] OFS_SNAPH   = 5'h14;

   localparam int unsigned STATUS_TO  = 0;
   localparam int unsigned STATUS_RUN = 1;
   localparam int unsigned CTRL_ITO   = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_START = 2;
   localparam int unsigned CTRL_STOP  = 3;

   typedef enum logic {
      IDLE,
      COUNT
   } timer_state_t;

endpackage

// File: rtl/timer_counter.sv
// Loadable 32-bit down-counter that saturates at zero and flags it.
module timer_counter #(
   parameter logic [31:0] RESET_VALUE = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] load_value,
   output logic [31:0] count,
   output logic        zero
);

   logic [31:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= RESET_VALUE;
      else if (load)
         count_q <= load_value;
      else if (en && !zero)
         count_q <= count_q - 32'd1;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped interval timer: register decode, run/idle FSM and read mux.
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFF202000,
   parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        irq
);

   timer_state_t state_q, state_d;
   logic         to_q, to_d;
   logic         ito_q, ito_d;
   logic         cont_q, cont_d;
   logic [31:0]  period_q, period_d;
   logic [31:0]  snap_q, snap_d;

   logic [4:0]   ofs;
   logic         wr, start, stop, per_wr, timeout;
   logic         cnt_load, cnt_en, cnt_zero;
   logic [31:0]  cnt_load_value, cnt_count;

   assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
   assign ofs     = {addr[4:2], 2'b00};
   assign wr      = we & sel;
   assign start   = wr && (ofs == OFS_CONTROL) && wdata[CTRL_START];
   assign stop    = wr && (ofs == OFS_CONTROL) && wdata[CTRL_STOP];
   assign per_wr  = wr && ((ofs == OFS_PERIODL) || (ofs == OFS_PERIODH));
   assign timeout = (state_q == COUNT) && cnt_zero;
   assign irq     = to_q & ito_q;

   timer_counter #(
      .RESET_VALUE(RESET_PERIOD)
   ) u_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load),
      .en        (cnt_en),
      .load_value(cnt_load_value),
      .count     (cnt_count),
      .zero      (cnt_zero)
   );

   always_comb begin
      state_d        = state_q;
      to_d           = to_q;
      ito_d          = ito_q;
      cont_d         = cont_q;
      period_d       = period_q;
      snap_d         = snap_q;
      cnt_load       = 1'b0;
      cnt_en         = 1'b0;
      cnt_load_value = period_q;

      if (wr) begin
         case (ofs)
            OFS_STATUS:  to_d = 1'b0;
            OFS_CONTROL: begin
               ito_d  = wdata[CTRL_ITO];
               cont_d = wdata[CTRL_CONT];
            end
            OFS_PERIODL: period_d[15:0]  = wdata[15:0];
            OFS_PERIODH: period_d[31:16] = wdata[15:0];
            OFS_SNAPL,
            OFS_SNAPH:   snap_d = cnt_count;
            default: ;
         endcase
      end

      // Timeout is evaluated after the register writes so a coincident
      // STATUS clear loses to the set, and STOP at zero still reloads.
      case (state_q)
         IDLE: begin
            if (start && !stop)
               state_d = COUNT;
         end
         COUNT: begin
            if (timeout) begin
               to_d     = 1'b1;
               cnt_load = 1'b1;
               if (!cont_q || stop)
                  state_d = IDLE;
            end else if (stop) begin
               state_d = IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (per_wr) begin
         state_d        = IDLE;
         cnt_load       = 1'b1;
         cnt_load_value = period_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         to_q     <= 1'b0;
         ito_q    <= 1'b0;
         cont_q   <= 1'b0;
         period_q <= RESET_PERIOD;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         to_q     <= to_d;
         ito_q    <= ito_d;
         cont_q   <= cont_d;
         period_q <= period_d;
         snap_q   <= snap_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (ofs)
            OFS_STATUS: begin
               rdata[STATUS_TO]  = to_q;
               rdata[STATUS_RUN] = (state_q == COUNT);
            end
            OFS_CONTROL: begin
               rdata[CTRL_ITO]  = ito_q;
               rdata[CTRL_CONT] = cont_q;
            end
            OFS_PERIODL: rdata[15:0] = period_q[15:0];
            OFS_PERIODH: rdata[15:0] = period_q[31:16];
            OFS_SNAPL:   rdata[15:0] = snap_q[15:0];
            OFS_SNAPH:   rdata[15:0] = snap_q[31:16];
            default:     rdata = '0;
         endcase
      end
   end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFF202000, 32-byte-aligned base of the register window.
REQ-002 Parameter RESET_PERIOD, default 32'd49999, value of the period register after reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 we  input  1  CPU store strobe (MemWrite).
REQ-006 addr  input  32  CPU byte address (DataAdr).
REQ-007 wdata  input  32  CPU store data (WriteData).
REQ-008 rdata  output  32  load data, combinational from addr; 0 when sel=0.
REQ-009 sel  output  1  combinational address hit: addr[31:5]==BASE_ADDR[31:5]; steers the top-level read mux.
REQ-010 irq  output  1  interrupt request, equal to TO & ITO.

Function
REQ-011 Register map, word offsets:
- 0x00 STATUS: bit0 TO (write of any value clears it), bit1 RUN (read-only).
- 0x04 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-1 action), bit3 STOP (write-1 action).
- 0x08 PERIODL = period[15:0]; 0x0C PERIODH = period[31:16].
- 0x10 SNAPL; 0x14 SNAPH.
- Upper read bits are zero.
REQ-012 Registers shall be written only on a clk edge with we=1 and sel=1; only wdata[15:0] is used.
REQ-013 Offsets 0x18 and 0x1C shall read 0, and writes to them shall be ignored.
REQ-014 CONTROL reads shall return {ITO, CONT} in bits [1:0], with bits 2 and 3 reading 0.
REQ-015 Two states, IDLE (RUN=0) and COUNT (RUN=1):
- START=1 with STOP=0 in IDLE -> COUNT.
- STOP=1 in COUNT -> IDLE, with the counter held.
- START in COUNT shall be ignored.
- START and STOP both 1 -> STOP wins.
REQ-016 In COUNT, the 32-bit counter shall decrement by 1 per clk while nonzero.
REQ-017 In COUNT with counter==0, the next edge shall set TO and reload counter<=period. RUN shall stay 1 if CONT=1 and clear if CONT=0.
REQ-018 Timing from a START edge with period P:
- TO rises on edge P+1 after the START edge.
- In continuous mode the timeout interval is P+1 cycles; P=0 times out every cycle.
REQ-019 A write to PERIODL or PERIODH shall:
- update its half of period,
- force RUN=0,
- load counter with the new full period value, all on the same edge.
REQ-020 A write to SNAPL or SNAPH shall copy the current counter into the 32-bit snap register. SNAPL/SNAPH reads shall return snap[15:0]/snap[31:16].
REQ-021 If a STATUS write coincides with a timeout edge, TO shall be 1 after that edge (set beats clear).
REQ-022 If a STOP write coincides with counter==0 in COUNT, TO shall be set, the counter reloaded, and RUN shall be 0.
REQ-023 Counter and period arithmetic is unsigned 32-bit and the counter shall never wrap below 0.

Reset
REQ-024 Reset shall set:
- TO=0, RUN=0, ITO=0, CONT=0,
- period=RESET_PERIOD, counter=RESET_PERIOD, snap=0,
- and therefore irq=0.
REQ-025 Reset asserted mid-count shall abort immediately (asynchronously) to IDLE with the above values, and no timeout shall be generated.

Structure
REQ-026 Package timer_pkg shall hold:
- the offset constants OFS_STATUS..OFS_SNAPH,
- the CONTROL/STATUS bit-index constants,
- the state enum timer_state_t {IDLE, COUNT}.
REQ-027 The loadable down-counter with zero detect shall be a sub-module named timer_counter, with inputs load/en/load_value and outputs count/zero. Register decode and the FSM shall stay in mmio_timer.

Verification
REQ-028 Scenario: write PERIODL=4, PERIODH=0, CONTROL=0x4 -> TO=1 and RUN=0 exactly 5 cycles after the START edge.
REQ-029 Scenario: CONTROL=0x7 with period 2 -> irq pulses set at 3-cycle intervals. A STATUS write lowers irq; it re-asserts at the next timeout.
REQ-030 Scenario: period 100, START, wait 10 cycles, write SNAPL -> SNAPL reads 91 and SNAPH reads 0.
REQ-031 Scenario: STATUS write on the same edge as a timeout -> TO=1 afterward. Writing CONTROL=0xC in IDLE -> RUN stays 0.
REQ-032 Scenario: reset asserted mid-count -> RUN=0 and irq=0 with no edge required; a read of PERIODL at offset 0x08 returns 0xC34F.
REQ-033 Scenario: addr=BASE_ADDR+0x20 -> sel=0 and rdata=0, with no register change on a write. addr=BASE_ADDR+0x18 -> sel=1 and rdata=0.
